mem_responder: RTL and testbench

Responder side of the load/store memory interface, driven by the execute stage's memory request port. It accepts one request at a time over a valid/ready handshake and performs word, halfword or byte reads and writes on a local word-organised storage array. After a fixed, parameterised latency it returns a response over a second valid/ready handshake. It replaces the ad-hoc storage memory hookup, so the pipeline can stall cleanly on data-memory access.

---
 rtl/mem_responder.sv | 216 +++++++++++++++++++++
 tb/tb_mem_responder.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: responder side of the load/store memory interface.
//
// Accepts one request at a time over a valid/ready handshake. It performs a byte, halfword
// or word read or write on a local word-organised array. After LATENCY cycles it returns a
// response over a second valid/ready handshake.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 4)
//   LATENCY      edges from request accept until rsp_valid is visible (>= 1)
//
// Ports:
//   clk, rst       single clock; synchronous active-high reset
//   req_valid/ready  request handshake
//   req_write      1 = store, 0 = load
//   req_addr       byte address
//   req_size       0 = byte, 1 = half, 2 = word, 3 = illegal
//   req_unsigned   loads zero-extend instead of sign-extend
//   req_wdata      right-justified store data
//   rsp_valid/ready  response handshake
//   rsp_rdata      extended load data; 0 for stores and errors
//   rsp_err        request rejected, no storage side effect
//
// Optional feature macro: MEM_RESPONDER_ALIGN_CHECK_EN
//   defined:   misaligned halfword/word accesses return rsp_err and do not write
//   undefined: misaligned accesses are forced aligned (low address bits ignored)

module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          write_q, write_d;
    logic [31:0]   addr_q, addr_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;

    logic [31:0]   mem [DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic [1:0]    off;
    logic [3:0]    be;
    logic [31:0]   wd_lanes;
    logic [31:0]   rd_word;
    logic [31:0]   rd_shift;
    logic [31:0]   load_data;
    logic          out_of_range;
    logic          misalign;
    logic          acc_err;
    logic          mem_we;

    assign idx          = addr_q[AW+1:2];
    // DEPTH_WORDS is a power of two, so any set bit above the array span is out of range.
    assign out_of_range = (addr_q >> (AW + 2)) != 32'd0;

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    assign misalign = ((size_q == 2'd1) && addr_q[0]) ||
                      ((size_q == 2'd2) && (addr_q[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign acc_err = (size_q == 2'd3) || out_of_range || misalign;

    // Lane selection; low bits that do not belong to the access size are dropped.
    always_comb begin
        off      = 2'b00;
        be       = 4'b0000;
        wd_lanes = wdata_q;
        unique case (size_q)
            2'd0: begin
                off      = addr_q[1:0];
                be       = 4'b0001 << off;
                wd_lanes = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                off      = {addr_q[1], 1'b0};
                be       = 4'b0011 << off;
                wd_lanes = {2{wdata_q[15:0]}};
            end
            2'd2: begin
                off      = 2'b00;
                be       = 4'b1111;
                wd_lanes = wdata_q;
            end
            default: begin
                off      = 2'b00;
                be       = 4'b0000;
                wd_lanes = wdata_q;
            end
        endcase
    end

    assign rd_word  = mem[idx];
    assign rd_shift = rd_word >> {off, 3'b000};

    always_comb begin
        load_data = rd_shift;
        unique case (size_q)
            2'd0: load_data = uns_q ? {24'd0, rd_shift[7:0]}
                                    : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'd1: load_data = uns_q ? {16'd0, rd_shift[15:0]}
                                    : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: load_data = rd_shift;
        endcase
    end

    // Next-state and datapath
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        addr_d      = addr_q;
        size_d      = size_q;
        uns_d       = uns_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_we      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata;
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d     = StResp;
                    rsp_err_d   = acc_err;
                    rsp_rdata_d = (acc_err || write_q) ? 32'd0 : load_data;
                    mem_we      = write_q && !acc_err;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d     = StIdle;
                    rsp_rdata_d = 32'd0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            addr_q      <= 32'd0;
            size_q      <= 2'd0;
            uns_q       <= 1'b0;
            wdata_q     <= 32'd0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Storage is not reset; reset still blocks a commit so an aborted store leaves no trace.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wd_lanes[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = (state_q == StIdle) && !rst;
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: directed vector table, hand-written multi-cycle sequences
// (response back-pressure, reset abort) and randomized traffic checked against a
// byte-addressed reference model.

module tb_mem_responder;

    localparam int unsigned DEPTH_WORDS = 1024;
    localparam int unsigned LATENCY     = 2;
    localparam int unsigned BYTES       = DEPTH_WORDS * 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_responder #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .LATENCY    (LATENCY)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err)
    );

    // Reference model: flat byte memory addressed directly by the byte address
    logic [7:0] mb [BYTES];

    function automatic void model_access(input logic w, input logic [31:0] a,
                                         input logic [1:0] s, input logic u,
                                         input logic [31:0] wd, output logic [31:0] rd,
                                         output logic e);
        int unsigned n;
        int unsigned base;
        logic [31:0] v;
        rd = 32'd0;
        e  = 1'b0;
        if (s == 2'd3 || a >= BYTES) begin
            e = 1'b1;
            return;
        end
        n = 1 << s;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        if (a % n != 0) begin
            e = 1'b1;
            return;
        end
`endif
        base = a - (a % n);
        if (w) begin
            for (int i = 0; i < int'(n); i++) mb[base + i] = wd[8*i +: 8];
            return;
        end
        v = 32'd0;
        for (int i = 0; i < int'(n); i++) v = v | (32'(mb[base + i]) << (8 * i));
        if (!u && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (!u && n == 2 && v[15]) v = v | 32'hFFFF_0000;
        rd = v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %08h, expected %08h", name, got, exp);
        end
    endtask

    // One complete transaction with rsp_ready held high; returns response and latency.
    task automatic xact(input logic w, input logic [31:0] a, input logic [1:0] s,
                        input logic u, input logic [31:0] wd,
                        output logic [31:0] rd, output logic e, output int lat);
        int n;
        @(negedge clk);
        req_valid    = 1'b1;
        req_write    = w;
        req_addr     = a;
        req_size     = s;
        req_unsigned = u;
        req_wdata    = wd;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = rsp_rdata;
        e  = rsp_err;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string       name;
        logic        w;
        logic [31:0] a;
        logic [1:0]  s;
        logic        u;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_e;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string name, input logic w, input logic [31:0] a,
                       input logic [1:0] s, input logic u, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_e);
        vec_t v;
        v.name = name; v.w = w; v.a = a; v.s = s; v.u = u; v.wd = wd;
        v.exp_rd = exp_rd; v.exp_e = exp_e;
        tbl.push_back(v);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, mrd;
        logic        e, me;
        int          lat;
        logic        seen;

        rst          = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_addr     = 32'd0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_wdata    = 32'd0;
        rsp_ready    = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("release_req_ready", 32'(req_ready), 32'd1);

        // Directed vectors: name, write, addr, size, unsigned, wdata, exp rdata, exp err
        add("st_w_10",      1, 32'h10,   2, 0, 32'hDEADBEEF, 32'h0,        0);
        add("ld_w_10",      0, 32'h10,   2, 0, 32'h0,        32'hDEADBEEF, 0);
        add("st_b_13",      1, 32'h13,   0, 0, 32'h7F,       32'h0,        0);
        add("ld_bs_13",     0, 32'h13,   0, 0, 32'h0,        32'h0000007F, 0);
        add("ld_w_10b",     0, 32'h10,   2, 0, 32'h0,        32'h7FADBEEF, 0);
        add("ld_bu_12",     0, 32'h12,   0, 1, 32'h0,        32'h000000AD, 0);
        add("ld_bs_12",     0, 32'h12,   0, 0, 32'h0,        32'hFFFFFFAD, 0);
        add("ld_hs_12",     0, 32'h12,   1, 0, 32'h0,        32'h00007FAD, 0);
        add("ld_hs_10",     0, 32'h10,   1, 0, 32'h0,        32'hFFFFBEEF, 0);
        add("ld_hu_10",     0, 32'h10,   1, 1, 32'h0,        32'h0000BEEF, 0);
        add("st_w_0",       1, 32'h0,    2, 0, 32'h0,        32'h0,        0);
        add("st_oor",       1, BYTES,    2, 0, 32'h55AA55AA, 32'h0,        1);
        add("ld_w_0_kept",  0, 32'h0,    2, 0, 32'h0,        32'h0,        0);
        add("ld_oor",       0, BYTES+4,  2, 0, 32'h0,        32'h0,        1);
        add("ld_size3",     0, 32'h10,   3, 0, 32'h0,        32'h0,        1);
        add("st_size3",     1, 32'h0,    3, 0, 32'hFFFFFFFF, 32'h0,        1);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        add("st_w_mis_2",   1, 32'h2,    2, 0, 32'h11223344, 32'h0,        1);
        add("ld_w_0_after", 0, 32'h0,    2, 0, 32'h0,        32'h0,        0);
        add("ld_h_mis_11",  0, 32'h11,   1, 0, 32'h0,        32'h0,        1);
`else
        add("st_w_mis_2",   1, 32'h2,    2, 0, 32'h11223344, 32'h0,        0);
        add("ld_w_0_after", 0, 32'h0,    2, 0, 32'h0,        32'h11223344, 0);
        add("ld_h_mis_11",  0, 32'h11,   1, 0, 32'h0,        32'hFFFFBEEF, 0);
`endif

        foreach (tbl[i]) begin
            xact(tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].u, tbl[i].wd, rd, e, lat);
            model_access(tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].u, tbl[i].wd, mrd, me);
            chk({tbl[i].name, "_rdata"}, rd, tbl[i].exp_rd);
            chk({tbl[i].name, "_err"}, 32'(e), 32'(tbl[i].exp_e));
            chk({tbl[i].name, "_lat"}, 32'(lat), 32'(LATENCY));
        end

        // Back-pressure: response held for 5 cycles, a request pulse in that window is ignored
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_size = 2'd2;
        req_unsigned = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("hold_lat", 32'(lat), 32'(LATENCY));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rsp_rdata", rsp_rdata, 32'h7FADBEEF);
            chk("hold_rsp_err", 32'(rsp_err), 32'd0);
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            if (k == 1) begin
                req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_size = 2'd2;
                req_wdata = 32'h12345678;
            end
            if (k == 2) req_valid = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("hold_after_valid", 32'(rsp_valid), 32'd0);
        chk("hold_after_rdata", rsp_rdata, 32'd0);
        chk("hold_after_err", 32'(rsp_err), 32'd0);
        xact(0, 32'h10, 2, 0, 32'h0, rd, e, lat);
        chk("hold_pulse_ignored", rd, 32'h7FADBEEF);

        // Reset during WAIT aborts a store
        xact(1, 32'h20, 2, 0, 32'h0, rd, e, lat);
        model_access(1, 32'h20, 2, 0, 32'h0, mrd, me);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_size = 2'd2;
        req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_req_ready_in_rst", 32'(req_ready), 32'd0);
        seen = rsp_valid;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_req_ready_release", 32'(req_ready), 32'd1);
        for (int k = 0; k < 6; k++) begin
            if (rsp_valid) seen = 1'b1;
            @(negedge clk);
        end
        chk("abort_no_rsp", 32'(seen), 32'd0);
        xact(0, 32'h20, 2, 0, 32'h0, rd, e, lat);
        chk("abort_no_write", rd, 32'h0);

        // Randomized traffic against the model; region preloaded so loads are defined
        for (int i = 0; i < 16; i++) begin
            logic [31:0] d;
            d = $urandom();
            xact(1, 32'h100 + 32'(4 * i), 2, 0, d, rd, e, lat);
            model_access(1, 32'h100 + 32'(4 * i), 2, 0, d, mrd, me);
        end
        for (int i = 0; i < 300; i++) begin
            logic        w;
            logic [31:0] a;
            logic [1:0]  s;
            logic        u;
            logic [31:0] d;
            int unsigned pick;
            w    = 1'($urandom_range(0, 1));
            u    = 1'($urandom_range(0, 1));
            d    = $urandom();
            a    = 32'h100 + 32'($urandom_range(0, 63));
            s    = 2'($urandom_range(0, 2));
            pick = $urandom_range(0, 15);
            if (pick == 0) s = 2'd3;
            if (pick == 1) a = $urandom() | 32'h0000_1000;
            xact(w, a, s, u, d, rd, e, lat);
            model_access(w, a, s, u, d, mrd, me);
            chk("rand_rdata", rd, mrd);
            chk("rand_err", 32'(e), 32'(me));
            chk("rand_lat", 32'(lat), 32'(LATENCY));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
